// File: rtl/run_ctrl_pkg.sv
// run_ctrl shared types: FSM states, halt causes
// and the ebreak encoding.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } run_state_t;

  typedef enum logic [2:0] {
    HC_NONE   = 3'd0,
    HC_REQ    = 3'd1,
    HC_BP     = 3'd2,
    HC_EBREAK = 3'd3,
    HC_STEP   = 3'd4
  } halt_cause_t;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

endpackage

// File: rtl/trig_sync.sv
// Two-flop synchroniser for the board trigger
// with a rising-edge detect on the synced level.
module trig_sync (
  input  logic clk,
  input  logic rst,
  input  logic trig_i,
  output logic rise_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= trig_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/run_ctrl.sv
// Run/step/halt sequencer for the RV32I core:
// commit enable, halt cause, cycle/instret counters.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger_i,
  input  logic                  step_i,
  input  logic                  halt_i,
  input  logic                  bp_en_i,
  input  logic [DATA_WIDTH-1:0] bp_addr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  output logic                  cpu_en_o,
  output logic [1:0]            state_o,
  output logic                  halted_o,
  output logic [2:0]            halt_cause_o,
  output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
  output logic [CNT_WIDTH-1:0]  instret_o
);

  logic trig_rise;

  trig_sync u_trig_sync (
    .clk    (clk),
    .rst    (rst),
    .trig_i (trigger_i),
    .rise_o (trig_rise)
  );

  run_state_t           state_q, state_d;
  halt_cause_t          cause_q, cause_d;
  halt_cause_t          stop_cause;
  logic                 skip_q, skip_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] ret_q, ret_d;
  logic                 is_ebreak, bp_hit;
  logic                 stop, active, cpu_en;
  logic                 leave;

  assign is_ebreak =
    instr_i == DATA_WIDTH'(EBREAK_INSTR);
  assign bp_hit = bp_en_i &&
    (pc_i == bp_addr_i) && !skip_q;
  assign stop   = halt_i | bp_hit | is_ebreak;
  assign active = (state_q == ST_RUN) ||
                  (state_q == ST_STEP);
  assign cpu_en = active && !stop;

  always_comb begin
    stop_cause = HC_BP;
    if (is_ebreak)   stop_cause = HC_EBREAK;
    else if (halt_i) stop_cause = HC_REQ;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    skip_d  = skip_q;
    leave   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!halt_i) begin
          if (trig_rise) begin
            state_d = ST_RUN;
            leave   = 1'b1;
          end else if (step_i) begin
            state_d = ST_STEP;
            leave   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_HALT;
          cause_d = stop_cause;
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
        cause_d = stop ? stop_cause : HC_STEP;
      end
      ST_HALT: begin
        // ebreak is sticky until reset
        if (cause_q != HC_EBREAK && !halt_i) begin
          if (trig_rise) begin
            state_d = ST_RUN;
            leave   = 1'b1;
          end else if (step_i) begin
            state_d = ST_STEP;
            leave   = 1'b1;
          end
          if (leave) cause_d = HC_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (active) skip_d = 1'b0;
    if (leave)  skip_d = 1'b1;
  end

  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if (state_q != ST_IDLE)
      cyc_d = cyc_q + CNT_WIDTH'(1);
    if (cpu_en)
      ret_d = ret_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= HC_NONE;
      skip_q  <= 1'b0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      skip_q  <= skip_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
    end
  end

  assign cpu_en_o     = cpu_en;
  assign state_o      = state_q;
  assign halted_o     = state_q == ST_HALT;
  assign halt_cause_o = cause_q;
  assign cycle_cnt_o  = cyc_q;
  assign instret_o    = ret_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: expectations are
// queued with a due cycle and compared when due.
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger, step, halt, bp_en;
  logic [31:0] bp_addr, pc, instr;

  logic        en, halted;
  logic [1:0]  st;
  logic [2:0]  cause;
  logic [31:0] cyc, ret;

  logic        en4, halted4;
  logic [1:0]  st4;
  logic [2:0]  cause4;
  logic [3:0]  cyc4, ret4;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBR = 32'h0010_0073;

  always #5 clk = ~clk;

  // pc_reg stand-in: advances by 4 on commit
  always @(posedge clk or posedge rst)
    if (rst) pc <= '0;
    else if (en) pc <= pc + 32'd4;

  run_ctrl dut (
    .clk(clk), .rst(rst), .trigger_i(trigger),
    .step_i(step), .halt_i(halt),
    .bp_en_i(bp_en), .bp_addr_i(bp_addr),
    .pc_i(pc), .instr_i(instr),
    .cpu_en_o(en), .state_o(st),
    .halted_o(halted), .halt_cause_o(cause),
    .cycle_cnt_o(cyc), .instret_o(ret)
  );

  run_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .trigger_i(trigger),
    .step_i(step), .halt_i(halt),
    .bp_en_i(bp_en), .bp_addr_i(bp_addr),
    .pc_i(pc), .instr_i(instr),
    .cpu_en_o(en4), .state_o(st4),
    .halted_o(halted4), .halt_cause_o(cause4),
    .cycle_cnt_o(cyc4), .instret_o(ret4)
  );

  typedef enum int {
    S_ST, S_EN, S_CAUSE, S_HLT, S_CYC,
    S_RET, S_PC, S_RET4, S_CYC4
  } sel_t;

  typedef struct {
    int          due;
    sel_t        sel;
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   ncyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h @%0d",
               tag, got, want, ncyc);
    end
  endtask

  function automatic logic [31:0] obs(sel_t s);
    case (s)
      S_ST:    return {30'd0, st};
      S_EN:    return {31'd0, en};
      S_CAUSE: return {29'd0, cause};
      S_HLT:   return {31'd0, halted};
      S_CYC:   return cyc;
      S_RET:   return ret;
      S_PC:    return pc;
      S_RET4:  return {28'd0, ret4};
      S_CYC4:  return {28'd0, cyc4};
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input int dly, input sel_t s,
                      input string tag,
                      input logic [31:0] v);
    exp_t e;
    e.due = ncyc + dly;
    e.sel = s;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t keep[$];
    foreach (sb[i]) begin
      if (sb[i].due <= ncyc)
        chk(sb[i].tag, obs(sb[i].sel), sb[i].val);
      else
        keep.push_back(sb[i]);
    end
    sb = keep;
  endtask

  task automatic tick();
    @(negedge clk);
    ncyc++;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; trigger = 1'b0; step = 1'b0;
    halt = 1'b0; bp_en = 1'b0; bp_addr = '0;
    instr = NOP;
    tick();
    push(1, S_ST,    "rst_state", 0);
    push(1, S_EN,    "rst_en",    0);
    push(1, S_HLT,   "rst_halted", 0);
    push(1, S_CAUSE, "rst_cause", 0);
    push(1, S_CYC,   "rst_cyc",   0);
    push(1, S_RET,   "rst_ret",   0);
    tick();
    rst = 1'b0;
    tick();

    // trigger pulse, run into breakpoint 0x10
    bp_en = 1'b1; bp_addr = 32'h10;
    trigger = 1'b1;
    push(1, S_ST,  "trig_lat1", 0);
    push(2, S_ST,  "trig_lat2", 0);
    push(3, S_ST,  "run_entry", 1);
    push(3, S_EN,  "run_en", 1);
    push(3, S_RET, "ret0", 0);
    push(4, S_RET, "ret1", 1);
    push(5, S_RET, "ret2", 2);
    push(6, S_RET, "ret3", 3);
    push(6, S_PC,  "pc_c", 32'h0c);
    push(7, S_PC,  "bp_pc", 32'h10);
    push(7, S_EN,  "bp_en0", 0);
    push(8, S_ST,  "bp_halt", 3);
    push(8, S_CAUSE, "bp_cause", 2);
    push(8, S_HLT, "bp_halted", 1);
    push(8, S_RET, "bp_ret", 4);
    push(8, S_CYC, "bp_cyc", 5);
    tick();
    trigger = 1'b0;
    ticks(7);

    // retrigger at breakpoint, executes once
    trigger = 1'b1;
    push(3, S_ST,  "resume_run", 1);
    push(3, S_EN,  "resume_skip", 1);
    push(3, S_CAUSE, "resume_none", 0);
    push(4, S_PC,  "resume_pc", 32'h14);
    push(4, S_RET, "resume_ret", 5);
    tick();
    trigger = 1'b0;
    ticks(3);

    // halt request, then halt+trigger together
    halt = 1'b1;
    push(1, S_ST,  "req_halt", 3);
    push(1, S_CAUSE, "req_cause", 1);
    push(1, S_RET, "req_ret", 5);
    tick();
    trigger = 1'b1;
    push(3, S_ST,  "halt_blk", 3);
    push(3, S_CAUSE, "halt_blk_c", 1);
    tick();
    trigger = 1'b0;
    ticks(2);
    halt = 1'b0;

    // two single steps
    step = 1'b1;
    push(1, S_ST,  "step1_st", 2);
    push(1, S_EN,  "step1_en", 1);
    push(1, S_CAUSE, "step1_c", 0);
    push(2, S_ST,  "step1_halt", 3);
    push(2, S_CAUSE, "step1_cause", 4);
    push(2, S_RET, "step1_ret", 6);
    tick();
    step = 1'b0;
    tick();
    step = 1'b1;
    push(1, S_ST,  "step2_st", 2);
    push(2, S_ST,  "step2_halt", 3);
    push(2, S_CAUSE, "step2_cause", 4);
    push(2, S_RET, "step2_ret", 7);
    push(2, S_PC,  "step2_pc", 32'h1c);
    push(2, S_CYC, "step2_cyc", 17);
    tick();
    step = 1'b0;
    tick();

    // halt_i together with breakpoint -> REQ
    bp_addr = 32'h24;
    trigger = 1'b1;
    push(3, S_ST,  "bp2_run", 1);
    push(5, S_PC,  "bp2_pc", 32'h24);
    push(5, S_EN,  "bp2_en0", 0);
    push(6, S_ST,  "bp2_halt", 3);
    push(6, S_CAUSE, "bp2_req", 1);
    push(6, S_RET, "bp2_ret", 9);
    tick();
    trigger = 1'b0;
    ticks(4);
    halt = 1'b1;
    tick();
    halt = 1'b0;

    // ebreak halts and locks out requests
    trigger = 1'b1;
    push(3, S_EN,  "eb_skip_en", 1);
    push(4, S_PC,  "eb_pc", 32'h28);
    tick();
    trigger = 1'b0;
    ticks(3);
    instr = EBR;
    push(0, S_EN,  "eb_en0", 0);
    push(0, S_ST,  "eb_run", 1);
    settle();
    push(1, S_ST,  "eb_halt", 3);
    push(1, S_CAUSE, "eb_cause", 3);
    push(1, S_RET, "eb_ret", 10);
    tick();
    instr = NOP;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    ticks(2);
    step = 1'b1;
    tick();
    step = 1'b0;
    push(1, S_ST,  "eb_lock", 3);
    push(1, S_CAUSE, "eb_lock_c", 3);
    push(1, S_EN,  "eb_lock_en", 0);
    tick();

    // reset, then wrap the 4-bit counter
    rst = 1'b1;
    push(0, S_ST,  "rst2_state", 0);
    push(0, S_RET, "rst2_ret", 0);
    push(0, S_CAUSE, "rst2_cause", 0);
    settle();
    tick();
    rst = 1'b0;
    bp_en = 1'b0;
    trigger = 1'b1;
    push(4,  S_RET4, "w_ret4_1", 1);
    push(18, S_RET4, "w_ret4_15", 15);
    push(19, S_RET,  "w_ret16", 16);
    push(19, S_RET4, "w_ret4_wrap", 0);
    push(19, S_CYC4, "w_cyc4_wrap", 0);
    tick();
    trigger = 1'b0;
    ticks(18);

    // async reset mid-RUN, trigger held through
    rst = 1'b1;
    trigger = 1'b1;
    push(0, S_EN,  "mid_rst_en", 0);
    push(0, S_ST,  "mid_rst_st", 0);
    push(0, S_CYC, "mid_rst_cyc", 0);
    push(0, S_RET, "mid_rst_ret", 0);
    settle();
    tick();
    rst = 1'b0;
    push(2, S_ST,  "hold_idle", 0);
    push(3, S_ST,  "hold_run", 1);
    push(5, S_ST,  "hold_halt", 3);
    push(5, S_CAUSE, "hold_req", 1);
    push(8, S_ST,  "hold_once", 3);
    ticks(4);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    ticks(3);
    trigger = 1'b0;
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
